glb_bank_rdrq_arbiter: RTL
==========================

GLB_BANK_RDRQ_ARBITER -- requirements
Module: glb_bank_rdrq_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of read requesters; index 0 is the processor port, indices 1..NUM_REQ-1 are the streaming and parallel-config ports.
REQ-002 Parameter ADDR_WIDTH, default 17: bank read-address width.
REQ-003 Parameter DATA_WIDTH, default 64: bank read-data width.
REQ-004 Parameter RD_LATENCY, default 3, minimum 1: cycles from bank_rd_en to bank_rd_data valid.
REQ-005 Parameter STARVE_LIMIT, default 15, range 1..15: wait-cycle threshold for the starvation guard.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port req_valid, input, NUM_REQ: per-requester read-request valid.
REQ-010 Port req_addr, input, NUM_REQ x ADDR_WIDTH: per-requester read address.
REQ-011 Port req_ready, output, NUM_REQ: per-requester grant; one-hot or zero.
REQ-012 Port bank_rd_en, output, 1: registered read enable to the bank.
REQ-013 Port bank_rd_addr, output, ADDR_WIDTH: registered read address to the bank.
REQ-014 Port bank_rd_data, input, DATA_WIDTH: bank read data, valid RD_LATENCY cycles after bank_rd_en.
REQ-015 Port rsp_valid, output, NUM_REQ: per-requester response valid; one-hot or zero.
REQ-016 Port rsp_data, output, DATA_WIDTH: response data shared by all requesters.

Function
REQ-017 req_ready SHALL be combinational from req_valid and the arbiter state, and SHALL be asserted only for the single granted requester whose req_valid is 1.
REQ-018 A handshake occurs when req_valid[i] and req_ready[i] are both 1; there is at most one handshake per cycle.
REQ-019 Base priority: requester 0 SHALL win whenever its req_valid is 1 and no starvation override is active.
REQ-020 Round-robin: among requesters 1..NUM_REQ-1, the search SHALL start at rr_ptr+1 and wrap from NUM_REQ-1 to 1.
REQ-021 rr_ptr SHALL update to the granted index only on a handshake with requesters 1..NUM_REQ-1; it SHALL hold otherwise.
REQ-022 On a handshake, bank_rd_en SHALL be 1 and bank_rd_addr SHALL equal the granted req_addr in the next cycle.
REQ-023 With no handshake, bank_rd_en SHALL be 0 and bank_rd_addr SHALL hold its previous value.
REQ-024 A tag pipeline of depth RD_LATENCY SHALL carry {valid, requester index} from each bank_rd_en.
REQ-025 When the tag output is valid with index i, rsp_valid[i] SHALL be 1 and rsp_data SHALL equal bank_rd_data in that cycle.
REQ-026 Total latency from handshake to rsp_valid SHALL be 1+RD_LATENCY cycles, fully pipelined at one request per cycle.
REQ-027 rsp_data SHALL pass bank_rd_data through unmasked; consumers qualify it with rsp_valid.
REQ-028 A requester deasserting req_valid before it is granted is legal; no state other than its wait counter is affected.
REQ-029 When all req_valid bits are 0, req_ready SHALL be 0 and no state other than the tag pipeline SHALL change.

Reset
REQ-030 On reset, req_ready, bank_rd_en, bank_rd_addr, rsp_valid and rsp_data SHALL be 0.
REQ-031 On reset, rr_ptr SHALL be NUM_REQ-1, so the first round-robin search starts at requester 1.
REQ-032 On reset, the tag pipeline and wait counters SHALL clear; in-flight responses are dropped with no rsp_valid pulse.

Configuration
REQ-033 Macro GLB_RDRQ_STARVE_GUARD_EN SHALL enable a 4-bit saturating wait counter per requester 1..NUM_REQ-1.
REQ-034 Counter update with the macro: increment when req_valid is 1 and the requester is not granted; clear on grant or when req_valid is 0; saturate at STARVE_LIMIT.
REQ-035 Override with the macro: any counter at STARVE_LIMIT SHALL beat requester 0; among several starved requesters, the lowest index wins; rr_ptr updates per REQ-021.
REQ-036 Without the macro, the counters SHALL be absent and requester 0 SHALL always hold absolute priority.

Verification
REQ-037 Reset release, req_valid=4'b0000 for 10 cycles -> all outputs 0, no bank_rd_en.
REQ-038 req_valid=4'b1110 held for 6 cycles -> grant order 1,2,3,1,2,3; bank_rd_en 6 consecutive cycles.
REQ-039 req_valid=4'b0011 held, with req_addr[0]=0x10 -> grant requester 0 every cycle; bank_rd_addr=0x10 one cycle after each grant.
REQ-040 Single request from requester 2 with RD_LATENCY=3 and bank model returning 0xABCD -> rsp_valid=4'b0100 and rsp_data=0xABCD exactly 4 cycles after the handshake.
REQ-041 With GLB_RDRQ_STARVE_GUARD_EN, STARVE_LIMIT=15 and req_valid=4'b0011 held -> requester 1 granted on cycle 16, then requester 0 resumes; without the macro, requester 1 is never granted.
REQ-042 Reset asserted with 3 reads in flight -> no rsp_valid after reset; next request served normally.

Source files
------------

// File: rtl/glb_bank_rdrq_arbiter.sv
// Read-request arbiter for one global-buffer bank: processor-first priority, round-robin
// among the remaining ports, and a tag pipeline that routes bank read data back to the requester.
// Optional starvation guard for ports 1..NUM_REQ-1 is enabled with `define GLB_RDRQ_STARVE_GUARD_EN.
module glb_bank_rdrq_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 64,
    parameter int RD_LATENCY   = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          bank_rd_en,
    output logic [ADDR_WIDTH-1:0]         bank_rd_addr,
    input  logic [DATA_WIDTH-1:0]         bank_rd_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                  grant_found;
    logic [IDXW-1:0]       grant_idx;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  bank_rd_en_q;
    logic [ADDR_WIDTH-1:0] bank_rd_addr_q;
    logic [IDXW-1:0]       rd_idx_q;
    logic [RD_LATENCY-1:0] tag_vld_q;
    logic [IDXW-1:0]       tag_idx_q [RD_LATENCY];

`ifdef GLB_RDRQ_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    logic [3:0] wait_cnt_q [1:NUM_REQ-1];
`endif

    // Starved ports first, then the processor, then a round-robin sweep starting after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef GLB_RDRQ_STARVE_GUARD_EN
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && wait_cnt_q[i] == STARVE_LIM) begin
                grant_found = 1'b1;
                grant_idx   = IDXW'(i);
            end
        end
`endif
        if (!grant_found && req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && i > int'(rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDXW'(i);
            end
        end
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && i <= int'(rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDXW'(i);
            end
        end
    end

    assign req_ready  = (grant_found && !reset) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign handshake  = |req_ready;
    assign grant_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign rr_ptr_d   = (handshake && grant_idx != '0) ? grant_idx : rr_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q       <= IDXW'(NUM_REQ - 1);
            bank_rd_en_q   <= 1'b0;
            bank_rd_addr_q <= '0;
            rd_idx_q       <= '0;
            tag_vld_q      <= '0;
            for (int s = 0; s < RD_LATENCY; s++) tag_idx_q[s] <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            bank_rd_en_q <= handshake;
            if (handshake) begin
                bank_rd_addr_q <= grant_addr;
                rd_idx_q       <= grant_idx;
            end
            // Tag stage 0 follows the bank enable, so the last stage lines up with returning data.
            tag_vld_q[0] <= bank_rd_en_q;
            tag_idx_q[0] <= rd_idx_q;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

`ifdef GLB_RDRQ_STARVE_GUARD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REQ; i++) wait_cnt_q[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REQ; i++) begin
                if (!req_valid[i] || req_ready[i]) begin
                    wait_cnt_q[i] <= '0;
                end else if (wait_cnt_q[i] < STARVE_LIM) begin
                    wait_cnt_q[i] <= wait_cnt_q[i] + 4'd1;
                end
            end
        end
    end
`endif

    assign bank_rd_en   = bank_rd_en_q;
    assign bank_rd_addr = bank_rd_addr_q;
    assign rsp_valid    = tag_vld_q[RD_LATENCY-1] ? (NUM_REQ'(1) << tag_idx_q[RD_LATENCY-1]) : '0;
    // Data is not qualified by rsp_valid; it is only forced low while reset is held.
    assign rsp_data     = reset ? '0 : bank_rd_data;

endmodule
